wavegen_instr_stream: RTL and testbench

Parametrised instruction-fetch and streaming engine for the waveform generator, the successor to the fixed 128-bit/32-bit CPU fetch path. It issues sequential memory read requests from a start address, buffers the returned instruction words in a prefetch FIFO, and serialises each instruction onto an AXI-Stream output of configurable width and beat order. Fetching ends at an end-of-program flag; `stop` aborts at any time. Unlike the previous fetch path, it keeps multiple instructions in flight through the FIFO and sustains back-to-back output under backpressure.

---
 rtl/wavegen_instr_stream_if.sv | 31 +++
 rtl/wavegen_instr_stream.sv | 190 +++++++++++++++++++
 tb/tb_wavegen_instr_stream.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wavegen_instr_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : wavegen_instr_stream_if
// Summary  : Memory read port plus AXI-Stream output of the instruction stream.
// Revision : 1.0
// ============================================================================
interface wavegen_instr_stream_if #(
   parameter int ADDR_W  = 33,
   parameter int INSTR_W = 128,
   parameter int OUT_W   = 32
);
   logic               rd_valid;
   logic [ADDR_W-1:0]  rd_addr;
   logic [INSTR_W-1:0] rd_data;
   logic               rd_ack;
   logic               axis_ready;
   logic [OUT_W-1:0]   axis_data;
   logic               axis_valid;
   logic               axis_last;

   modport master (
      output rd_valid, rd_addr, axis_data, axis_valid, axis_last,
      input  rd_data, rd_ack, axis_ready
   );

   modport slave (
      input  rd_valid, rd_addr, axis_data, axis_valid, axis_last,
      output rd_data, rd_ack, axis_ready
   );
endinterface
`default_nettype wire

// File: rtl/wavegen_instr_stream.sv
`default_nettype none
// ============================================================================
// Module   : wavegen_instr_stream
// Summary  : Sequential instruction fetch into a prefetch FIFO, serialised
//            onto an AXI-Stream output in configurable beat order.
// Revision : 1.0
// ============================================================================
module wavegen_instr_stream #(
   parameter int ADDR_W     = 33,
   parameter int INSTR_W    = 128,
   parameter int OUT_W      = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_STEP  = 16,
   parameter int LSB_FIRST  = 1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic [ADDR_W-1:0]      start_addr,
   wavegen_instr_stream_if.master bus,
   output logic                   busy,
   output logic                   done
);

   localparam int BPI    = INSTR_W / OUT_W;
   localparam int BEAT_W = (BPI > 1) ? $clog2(BPI) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPI - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic               r_start_d;
   logic [ADDR_W-1:0]  r_addr;

   logic [INSTR_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic [INSTR_W-1:0] r_shift;
   logic [BEAT_W-1:0]  r_beat;
   logic               r_svalid;
   logic               r_send;
   logic [BEAT_W-1:0]  w_slice;

   logic               w_start_edge;
   logic               w_fifo_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_hs;
   logic               w_last_beat;

   assign w_start_edge = start & ~r_start_d;
   assign w_fifo_empty = (r_count == '0);
   assign w_hs         = r_svalid & bus.axis_ready;
   assign w_last_beat  = (r_beat == LAST_BEAT);
   // rd_valid is only ever high in REQ, so acks arriving in IDLE/DRAIN are dropped
   assign w_push       = bus.rd_valid & bus.rd_ack & ~stop;
   assign w_pop        = ~w_fifo_empty & (~r_svalid | (w_hs & w_last_beat)) & ~stop;

   // ------------------------------------------------------------------------
   // Fetch FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (stop) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_start_edge) w_next_state = ST_REQ;
            ST_REQ:   if (w_push && bus.rd_data[INSTR_W-1]) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_fifo_empty && !r_svalid) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.rd_valid = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_REQ: begin
            busy         = 1'b1;
            bus.rd_valid = (r_count < FULL_CNT);
         end
         ST_DRAIN: begin
            busy = 1'b1;
            done = w_fifo_empty & ~r_svalid;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_start_d <= 1'b0;
         r_addr    <= '0;
      end else begin
         r_start_d <= start;
         if (!stop) begin
            if (r_state == ST_IDLE && w_start_edge) begin
               r_addr <= start_addr;
            end else if (w_push && !bus.rd_data[INSTR_W-1]) begin
               r_addr <= r_addr + ADDR_W'(ADDR_STEP);
            end
         end
      end
   end

   assign bus.rd_addr = r_addr;

   // ------------------------------------------------------------------------
   // Prefetch FIFO (power-of-two depth, pointers wrap naturally)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || stop) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Serializer: reloads on the final beat's handshake to avoid a bubble
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || stop) begin
         r_shift  <= '0;
         r_beat   <= '0;
         r_svalid <= 1'b0;
         r_send   <= 1'b0;
      end else if (w_pop) begin
         r_shift  <= r_mem[r_rd_ptr];
         r_beat   <= '0;
         r_svalid <= 1'b1;
         r_send   <= r_mem[r_rd_ptr][INSTR_W-1];
      end else if (w_hs) begin
         if (w_last_beat) begin
            r_svalid <= 1'b0;
         end else begin
            r_beat <= r_beat + 1'b1;
         end
      end
   end

   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign w_slice = r_beat;
      end else begin : g_msb_first
         assign w_slice = LAST_BEAT - r_beat;
      end
   endgenerate

   assign bus.axis_data  = r_shift[w_slice*OUT_W +: OUT_W];
   assign bus.axis_valid = r_svalid;
   assign bus.axis_last  = r_svalid & r_send & w_last_beat;

endmodule
`default_nettype wire

// File: tb/tb_wavegen_instr_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_wavegen_instr_stream
// Summary  : Self-checking bench: table-driven programs, random programs
//            against a beat-queue model, plus abort/start corner sequences.
// Revision : 1.0
// ============================================================================
module tb_wavegen_instr_stream;

   localparam logic [127:0] FIXED_WORD = 128'hA000_0000_0000_0000_0000_0D00_0000_0011;

   typedef struct {
      int          n_words;
      logic [32:0] base;
      int          lat;
      int          ready_mode;    // 0 always ready, 1 toggling, 2 random
      bit          fixed_word;
      int          exp_reqs;
      int          exp_beats;
      logic [32:0] exp_last_addr;
      int          exp_gaps;      // negative: not checked
   } vec_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [32:0] start_addr;
   logic        busy;
   logic        done;

   logic        start2;
   logic        stop2;
   logic [7:0]  sa2;
   logic        busy2;
   logic        done2;

   int total;
   int bad;
   vec_t vecs [5];

   wavegen_instr_stream_if #(.ADDR_W(33), .INSTR_W(128), .OUT_W(32)) bus ();
   wavegen_instr_stream_if #(.ADDR_W(8),  .INSTR_W(256), .OUT_W(64)) bus2 ();

   wavegen_instr_stream #(
      .ADDR_W(33), .INSTR_W(128), .OUT_W(32), .FIFO_DEPTH(4), .ADDR_STEP(16), .LSB_FIRST(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .start_addr(start_addr),
      .bus(bus), .busy(busy), .done(done)
   );

   wavegen_instr_stream #(
      .ADDR_W(8), .INSTR_W(256), .OUT_W(64), .FIFO_DEPTH(4), .ADDR_STEP(16), .LSB_FIRST(0)
   ) dut2 (
      .clk(clk), .rst(rst), .start(start2), .stop(stop2), .start_addr(sa2),
      .bus(bus2), .busy(busy2), .done(done2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launches one program on the default DUT and plays memory + sink.
   task automatic run_program(input int n, input logic [32:0] base, input int lat,
                              input int rmode, input bit fixed, input bit hold_start,
                              output int reqs, output int beats,
                              output logic [32:0] last_addr, output int gaps);
      logic [127:0] prog[$];
      logic [31:0]  exp_q[$];
      bit           last_q[$];
      logic [127:0] w;
      logic [32:0]  exp_addr;
      logic [31:0]  prev_data;
      bit           prev_stall, prev_last, pending;
      int           cnt, widx, ack_cyc, valid_cyc, last_hs_cyc, done_cnt, done_cyc;
      int           acked, completed, max_infl;

      for (int i = 0; i < n; i++) begin
         w = {$urandom, $urandom, $urandom, $urandom};
         w[127] = (i == n - 1);
         if (fixed) w = FIXED_WORD;
         prog.push_back(w);
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back(w[32*b +: 32]);
            last_q.push_back((i == n - 1) && (b == 3));
         end
      end

      reqs = 0; beats = 0; gaps = 0; last_addr = '0;
      pending = 0; cnt = 0; widx = 0; ack_cyc = -1; valid_cyc = -1;
      last_hs_cyc = -10; done_cnt = 0; done_cyc = -10;
      acked = 0; completed = 0; max_infl = 0;
      prev_stall = 0; prev_last = 0; prev_data = '0;
      exp_addr = base;

      start = 1'b0;
      step();
      start_addr = base;
      start = 1'b1;
      step();
      check("launch rd_valid", bus.rd_valid, 1'b1);
      if (!hold_start) start = 1'b0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (prev_stall) begin
            check("stall stable", {bus.axis_valid, bus.axis_last, bus.axis_data},
                  {1'b1, prev_last, prev_data});
         end

         bus.rd_ack = 1'b0;
         if (!pending && bus.rd_valid) begin
            if (widx >= n) check("extra request", 1'b1, 1'b0);
            check("rd_addr", bus.rd_addr, exp_addr);
            pending   = 1;
            cnt       = lat;
            last_addr = bus.rd_addr;
            reqs++;
         end else if (pending) begin
            check("request held", {bus.rd_valid, bus.rd_addr}, {1'b1, last_addr});
         end
         if (pending) begin
            if (cnt == 0) begin
               bus.rd_ack  = 1'b1;
               bus.rd_data = (widx < n) ? prog[widx] : '0;
               if (ack_cyc < 0) ack_cyc = cyc;
               widx++;
               acked++;
               pending  = 0;
               exp_addr = exp_addr + 33'd16;
            end else begin
               cnt--;
            end
         end

         case (rmode)
            0:       bus.axis_ready = 1'b1;
            1:       bus.axis_ready = (cyc % 2 == 0);
            default: bus.axis_ready = 1'($urandom_range(0, 1));
         endcase

         if (bus.axis_valid && valid_cyc < 0) valid_cyc = cyc;
         if (valid_cyc >= 0 && !bus.axis_valid && exp_q.size() != 0) gaps++;
         if (bus.axis_valid && bus.axis_ready) begin
            if (exp_q.size() == 0) begin
               check("extra beat", 1'b1, 1'b0);
            end else begin
               check("beat data", bus.axis_data, exp_q.pop_front());
               check("beat last", bus.axis_last, last_q.pop_front());
            end
            beats++;
            if (beats % 4 == 0) completed++;
            if (bus.axis_last) last_hs_cyc = cyc;
         end

         if (done) begin
            check("busy at done", busy, 1'b1);
            done_cnt++;
            done_cyc = cyc;
         end
         if (acked - completed > max_infl) max_infl = acked - completed;

         prev_stall = bus.axis_valid & ~bus.axis_ready;
         prev_last  = bus.axis_last;
         prev_data  = bus.axis_data;

         if (done_cnt > 0 && cyc > done_cyc + 2) break;
         step();
      end
      bus.rd_ack = 1'b0;
      bus.axis_ready = 1'b1;

      check("done count", done_cnt, 1);
      check("done timing", done_cyc, last_hs_cyc + 1);
      check("missing beats", exp_q.size(), 0);
      check("read latency", valid_cyc - ack_cyc, 2);
      check("fifo bound", (max_infl <= 5), 1'b1);
      check("busy cleared", busy, 1'b0);
   endtask

   // Wide DUT: 256-bit words, 64-bit beats, MSB first, 8-bit address wrap.
   task automatic run_wide();
      logic [255:0] prog [2];
      logic [63:0]  eq[$];
      bit           lq[$];
      logic [255:0] w;
      bit           p;
      int           widx, reqs, beats, dcnt, dcyc;

      for (int i = 0; i < 2; i++) begin
         w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         w[255] = (i == 1);
         prog[i] = w;
         for (int b = 0; b < 4; b++) begin
            eq.push_back(w[255-64*b -: 64]);
            lq.push_back((i == 1) && (b == 3));
         end
      end

      p = 0; widx = 0; reqs = 0; beats = 0; dcnt = 0; dcyc = -10;
      bus2.axis_ready = 1'b1;
      start2 = 1'b0;
      sa2 = 8'hF0;
      step();
      start2 = 1'b1;
      step();
      start2 = 1'b0;

      for (int cyc = 0; cyc < 200; cyc++) begin
         bus2.rd_ack = 1'b0;
         if (p) begin
            bus2.rd_ack  = 1'b1;
            bus2.rd_data = (widx < 2) ? prog[widx] : '0;
            widx++;
            p = 0;
         end else if (bus2.rd_valid) begin
            check("wide rd_addr", bus2.rd_addr, 8'(8'hF0 + 16 * reqs));
            p = 1;
            reqs++;
         end
         if (bus2.axis_valid) begin
            if (eq.size() == 0) begin
               check("wide extra beat", 1'b1, 1'b0);
            end else begin
               check("wide beat data", bus2.axis_data, eq.pop_front());
               check("wide beat last", bus2.axis_last, lq.pop_front());
            end
            beats++;
         end
         if (done2) begin
            dcnt++;
            dcyc = cyc;
         end
         if (dcnt > 0 && cyc > dcyc + 2) break;
         step();
      end
      bus2.rd_ack = 1'b0;
      check("wide reqs", reqs, 2);
      check("wide beats", beats, 8);
      check("wide done count", dcnt, 1);
   endtask

   initial begin
      int          reqs, beats, gaps, hs, guard, n, lat;
      logic [32:0] laddr, base;
      logic [127:0] w0;
      bit          flag;

      total = 0;
      bad   = 0;
      rst = 1'b1; start = 1'b0; stop = 1'b0; start_addr = '0;
      bus.rd_ack = 1'b0; bus.rd_data = '0; bus.axis_ready = 1'b1;
      start2 = 1'b0; stop2 = 1'b0; sa2 = '0;
      bus2.rd_ack = 1'b0; bus2.rd_data = '0; bus2.axis_ready = 1'b1;
      repeat (3) step();

      check("reset rd_valid",   bus.rd_valid,   1'b0);
      check("reset rd_addr",    bus.rd_addr,    33'h0);
      check("reset axis_valid", bus.axis_valid, 1'b0);
      check("reset axis_data",  bus.axis_data,  32'h0);
      check("reset axis_last",  bus.axis_last,  1'b0);
      check("reset busy",       busy,           1'b0);
      check("reset done",       done,           1'b0);
      rst = 1'b0;
      step();

      vecs[0] = '{1, 33'h0,           3, 0, 1'b1, 1, 4,  33'h0,        0};
      vecs[1] = '{3, 33'h0,           1, 0, 1'b0, 3, 12, 33'h20,       0};
      vecs[2] = '{8, 33'h0,           1, 1, 1'b0, 8, 32, 33'h70,      -1};
      vecs[3] = '{5, 33'h1_FFFF_FFE0, 0, 2, 1'b0, 5, 20, 33'h20,      -1};
      vecs[4] = '{2, 33'h1000,        4, 0, 1'b0, 2, 8,  33'h1010,    -1};

      for (int i = 0; i < 5; i++) begin
         run_program(vecs[i].n_words, vecs[i].base, vecs[i].lat, vecs[i].ready_mode,
                     vecs[i].fixed_word, 1'b0, reqs, beats, laddr, gaps);
         check("vec reqs",      reqs,  vecs[i].exp_reqs);
         check("vec beats",     beats, vecs[i].exp_beats);
         check("vec last addr", laddr, vecs[i].exp_last_addr);
         if (vecs[i].exp_gaps >= 0) check("vec gaps", gaps, vecs[i].exp_gaps);
      end

      for (int r = 0; r < 6; r++) begin
         n    = $urandom_range(1, 10);
         lat  = $urandom_range(0, 4);
         base = {1'($urandom_range(0, 1)), 32'($urandom)};
         run_program(n, base, lat, 2, 1'b0, 1'b0, reqs, beats, laddr, gaps);
         check("rand reqs",      reqs,  n);
         check("rand beats",     beats, 4 * n);
         check("rand last addr", laddr, base + 33'(16 * (n - 1)));
      end

      // Abort while beat 2 is on the bus and the second request is outstanding.
      w0 = {$urandom, $urandom, $urandom, $urandom};
      w0[127] = 1'b0;
      bus.axis_ready = 1'b1;
      start = 1'b0;
      step();
      start_addr = 33'h40;
      start = 1'b1;
      step();
      start = 1'b0;
      check("stop launch", bus.rd_valid, 1'b1);
      bus.rd_ack = 1'b1;
      bus.rd_data = w0;
      step();
      bus.rd_ack = 1'b0;
      hs = 0;
      guard = 0;
      while (hs < 2 && guard < 20) begin
         if (bus.axis_valid && bus.axis_ready) hs++;
         step();
         guard++;
      end
      check("stop beat2 data", bus.axis_data, w0[95:64]);
      check("stop req outstanding", {bus.rd_valid, bus.rd_addr}, {1'b1, 33'h50});
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop rd_valid",   bus.rd_valid,   1'b0);
      check("stop axis_valid", bus.axis_valid, 1'b0);
      check("stop axis_data",  bus.axis_data,  32'h0);
      check("stop axis_last",  bus.axis_last,  1'b0);
      check("stop busy",       busy,           1'b0);
      check("stop done",       done,           1'b0);
      bus.rd_ack = 1'b1;
      bus.rd_data = {1'b1, 127'h5A5A};
      step();
      bus.rd_ack = 1'b0;
      flag = 0;
      for (int c = 0; c < 4; c++) begin
         flag = flag | bus.axis_valid | bus.rd_valid | busy | done;
         step();
      end
      check("late ack ignored", flag, 1'b0);
      run_program(2, 33'h40, 1, 0, 1'b0, 1'b0, reqs, beats, laddr, gaps);
      check("refetch reqs",  reqs,  2);
      check("refetch beats", beats, 8);
      check("refetch addr",  laddr, 33'h50);

      // Start held high through completion must not relaunch.
      run_program(2, 33'h200, 1, 0, 1'b0, 1'b1, reqs, beats, laddr, gaps);
      flag = 0;
      for (int c = 0; c < 5; c++) begin
         flag = flag | bus.rd_valid | busy;
         step();
      end
      check("held start no relaunch", flag, 1'b0);
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      check("relaunch after new edge", bus.rd_valid, 1'b1);
      start = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      step();

      // Start edge and stop in the same cycle.
      start = 1'b1;
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("start+stop rd_valid", bus.rd_valid, 1'b0);
      check("start+stop busy",     busy,         1'b0);
      step();
      check("start+stop held", {bus.rd_valid, busy}, 2'b00);
      start = 1'b0;
      step();

      run_wide();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
